gray_counter_display: RTL and testbench
=======================================

# gray_counter_display

Parametrised successor to the team's 4-bit binary-to-Gray 7-segment decoder. The block is a sequential up/down counter of WIDTH bits with a prescaled step, a simultaneous Gray-code output, and a time-multiplexed multi-digit 7-segment driver. The driver shows either the binary or the Gray value in hex. It sits between the board switches/buttons and the on-board 7-segment bank, and replaces the purely combinational single-digit path.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; multiple of 4, ≥4; DIGITS = WIDTH/4 (derived).
- TICK_DIV, 50_000_000, clock cycles per count step; ≥1.
- SCAN_DIV, 50_000, clock cycles per display digit slot; ≥1.
- ACTIVE_LOW, 1, 1 = seg/an driven active-low, 0 = active-high.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; 0 freezes prescaler and counter.
- up  in  1  direction; 1 = increment, 0 = decrement.
- mode  in  1  display select; 0 = binary value, 1 = Gray value.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- count_bin  out  WIDTH  registered binary count.
- count_gray  out  WIDTH  count_bin ^ (count_bin >> 1), combinational from count_bin.
- wrap  out  1  one-cycle pulse on modulo wrap.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- an  out  DIGITS  one-hot digit enable, polarity per ACTIVE_LOW.

## Operation
- Prescaler div_cnt counts 0..TICK_DIV-1 while en=1, holds while en=0. The internal tick is asserted in the cycle where en=1 and div_cnt=TICK_DIV-1; div_cnt then returns to 0. With TICK_DIV=1, tick fires on every enabled cycle.
- On tick, count_bin becomes count_bin+1 (up=1) or count_bin-1 (up=0), modulo 2^WIDTH.
- wrap is registered. It is 1 for exactly the cycle in which count_bin first shows 0 after an up-step from all-ones, or all-ones after a down-step from 0. Otherwise it is 0.
- load has priority over tick. count_bin becomes load_val, div_cnt becomes 0, and wrap stays 0 even if the value wraps.
- up or mode may change at any time. A change takes effect on the next tick for up, and on the next display update for mode.
- Display value is disp = mode ? count_gray : count_bin. Digit k shows nibble disp[4k+3:4k]; digit 0 is the least-significant nibble.
- Scan counter counts 0..SCAN_DIV-1 continuously, independent of en. On its terminal value, digit index advances k → k+1, and DIGITS-1 → 0.
- Hex font: 0-9, A, b, C, d, E, F.
  - 6 has segment a lit; 9 has segment d lit; 7 = a,b,c only.
  - Example glyphs (active-high {g..a}): 0 = 0111111, F = 1110001, 3 = 1001111, A = 1110111, 2 = 1011011.
- ACTIVE_LOW=1 inverts both seg and an.

## Timing
- Reset (asynchronous, takes effect immediately without a clock edge):
  - count_bin = 0, count_gray = 0, wrap = 0.
  - div_cnt = 0, scan counter = 0, digit index = 0.
  - seg = all segments off, an = all digits off.
- seg/an are registered from the current digit index and disp. There is 1 cycle of latency from a count_bin change or mode change to the new glyph on seg.
- First active an appears on the first clock edge after rst deasserts, and selects digit 0.
- Count latency:
  - the tick cycle's edge updates count_bin;
  - count_gray follows in the same cycle;
  - wrap is high in that same post-edge cycle.
- Load latency: count_bin equals load_val on the edge where load=1.
- rst asserted mid-count or mid-scan discards all progress. After release, counting resumes from 0 with a full TICK_DIV interval to the first step.

## Test plan
Bench parameters: WIDTH=8, TICK_DIV=4, SCAN_DIV=2, ACTIVE_LOW=0.
- Up count: reset, then en=1, up=1 for 16 cycles → count_bin 0,1,2,3,4 with one step every 4 cycles; count_gray 00,01,03,02,06; wrap stays 0.
- Up wrap: load 0xFF, then en=1, up=1 → before the step, count_gray=0x80. After 4 cycles, count_bin=0x00 with wrap=1 for exactly one cycle.
- Down wrap and hold:
  - up=0 from 0x00 → 0xFF with a wrap pulse.
  - Then en=0 for 20 cycles → count_bin stays 0xFF and wrap stays 0.
- Display: load 0x2A, en=0.
  - mode=1: digit 0 shows F (1110001) and digit 1 shows 3 (1001111); an alternates 01/10 every 2 cycles.
  - mode=0: digit 0 shows A (1110111), digit 1 shows 2 (1011011), with 1-cycle latency.
- Load versus tick: assert load with load_val=0x10 in a tick cycle → count_bin=0x10, not 0x11. The next step to 0x11 occurs exactly 4 enabled cycles later.
- Asynchronous reset: assert rst between clock edges while count_bin=0x37 → all outputs reach reset values before the next edge. After release, count_bin=0x01 after 4 cycles.

Source files
------------

// File: rtl/gray_counter_display.sv
// ---------------------------------------------------------------------------
// gray_counter_display
//
// Prescaled WIDTH-bit up/down counter with a simultaneous Gray-code view and
// a time-multiplexed hex driver for a bank of DIGITS = WIDTH/4 seven-segment
// digits. The driver shows either the binary or the Gray value.
//
// Parameters
//   WIDTH      counter width in bits (multiple of 4, >= 4)
//   TICK_DIV   clock cycles per count step (>= 1)
//   SCAN_DIV   clock cycles per display digit slot (>= 1)
//   ACTIVE_LOW 1 = seg/an driven active-low, 0 = active-high
//
// Ports
//   clk         system clock, all state on rising edge
//   rst         asynchronous, active-high reset
//   en          count enable; 0 freezes prescaler and counter
//   up          direction; 1 = increment, 0 = decrement
//   mode        display select; 0 = binary value, 1 = Gray value
//   load        synchronous load strobe (wins over a count step)
//   load_val    value loaded when load = 1
//   count_bin   registered binary count
//   count_gray  count_bin ^ (count_bin >> 1)
//   wrap        one-cycle pulse when a step wraps modulo 2^WIDTH
//   seg         segments {g,f,e,d,c,b,a}
//   an          one-hot digit enable, digit 0 = least-significant nibble
// ---------------------------------------------------------------------------
module gray_counter_display #(
    parameter int WIDTH      = 8,
    parameter int TICK_DIV   = 50_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   up,
    input  logic                   mode,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    output logic [WIDTH-1:0]       count_bin,
    output logic [WIDTH-1:0]       count_gray,
    output logic                   wrap,
    output logic [6:0]             seg,
    output logic [(WIDTH/4)-1:0]   an
);

    localparam int DIGITS = WIDTH / 4;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
    localparam logic              POL       = (ACTIVE_LOW != 0);

    // -----------------------------------------------------------------------
    // Count path
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [WIDTH-1:0] count_r;
    logic             wrap_r;

    assign tick = en && (div_cnt == DIV_LAST);

    // Prescaler: a load restarts the interval so the next step is a full
    // TICK_DIV enabled cycles after the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (load) begin
            div_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // wrap is decided from the pre-step value so it lines up with the cycle
    // in which the wrapped value first appears on count_bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else if (load) begin
            count_r <= load_val;
            wrap_r  <= 1'b0;
        end else if (tick) begin
            if (up) begin
                count_r <= count_r + 1'b1;
                wrap_r  <= (count_r == '1);
            end else begin
                count_r <= count_r - 1'b1;
                wrap_r  <= (count_r == '0);
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign count_bin  = count_r;
    assign count_gray = count_r ^ (count_r >> 1);
    assign wrap       = wrap_r;

    // -----------------------------------------------------------------------
    // Display scan
    // -----------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [DIG_W-1:0]  digit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (digit_idx == DIG_LAST) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Hex font, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0111111;
            4'h1:    g = 7'b0000110;
            4'h2:    g = 7'b1011011;
            4'h3:    g = 7'b1001111;
            4'h4:    g = 7'b1100110;
            4'h5:    g = 7'b1101101;
            4'h6:    g = 7'b1111101;
            4'h7:    g = 7'b0000111;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1101111;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b1111100;
            4'hC:    g = 7'b0111001;
            4'hD:    g = 7'b1011110;
            4'hE:    g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        return g;
    endfunction

    logic [WIDTH-1:0]  disp;
    logic [3:0]        nibble;
    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] an_nxt;

    assign disp = mode ? count_gray : count_bin;

    // Nibble mux and one-hot enable built by comparing against each digit
    // position, which keeps the select width independent of WIDTH.
    always_comb begin
        nibble = '0;
        an_nxt = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (digit_idx == DIG_W'(k)) begin
                nibble    = disp[4*k +: 4];
                an_nxt[k] = 1'b1;
            end
        end
        seg_nxt = hex_glyph(nibble);
    end

    // Drive registers hold active-high values; reset leaves everything dark
    // regardless of output polarity.
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] an_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= '0;
            an_r  <= '0;
        end else begin
            seg_r <= seg_nxt;
            an_r  <= an_nxt;
        end
    end

    assign seg = seg_r ^ {7{POL}};
    assign an  = an_r ^ {DIGITS{POL}};

endmodule

// File: tb/tb_gray_counter_display.sv
// ---------------------------------------------------------------------------
// tb_gray_counter_display
//
// Drives directed and random stimulus into gray_counter_display (WIDTH=8,
// TICK_DIV=4, SCAN_DIV=2, ACTIVE_LOW=0). A driver predicts each post-edge
// output set from an arithmetic reference model and queues it; a monitor
// pops one entry per clock and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_gray_counter_display;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int DIGITS   = WIDTH / 4;
    localparam int MODV     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             up = 1'b1;
    logic             mode = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count_bin;
    logic [WIDTH-1:0] count_gray;
    logic             wrap;
    logic [6:0]       seg;
    logic [DIGITS-1:0] an;

    gray_counter_display #(
        .WIDTH     (WIDTH),
        .TICK_DIV  (TICK_DIV),
        .SCAN_DIV  (SCAN_DIV),
        .ACTIVE_LOW(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .count_bin (count_bin),
        .count_gray(count_gray),
        .wrap      (wrap),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0..F.
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        int cnt;
        int gray;
        int wrp;
        int sg;
        int a;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: counter value, enabled cycles since last step,
    // cycles into the current digit slot, digit being scanned.
    int m_cnt   = 0;
    int m_since = 0;
    int m_slot  = 0;
    int m_digit = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_since = 0;
        m_slot  = 0;
        m_digit = 0;
    endtask

    // One clock of stimulus: drive at the falling edge, predict what the
    // outputs must read after the following rising edge, queue it.
    task automatic cycle(input bit i_en, input bit i_up, input bit i_mode,
                         input bit i_load, input int lv);
        exp_t e;
        int   disp;
        int   nxt;
        int   w;
        @(negedge clk);
        rst      = 1'b0;
        en       = i_en;
        up       = i_up;
        mode     = i_mode;
        load     = i_load;
        load_val = WIDTH'(lv);

        disp = i_mode ? gray_of(m_cnt) : m_cnt;
        e.sg = int'(FONT[(disp >> (4 * m_digit)) % 16]);
        e.a  = 1 << m_digit;

        w = 0;
        if (i_load) begin
            m_cnt   = lv % MODV;
            m_since = 0;
        end else if (i_en && m_since == TICK_DIV - 1) begin
            nxt     = i_up ? (m_cnt + 1) % MODV : (m_cnt + MODV - 1) % MODV;
            w       = i_up ? int'(nxt < m_cnt) : int'(nxt > m_cnt);
            m_cnt   = nxt;
            m_since = 0;
        end else if (i_en) begin
            m_since++;
        end

        m_slot++;
        if (m_slot == SCAN_DIV) begin
            m_slot  = 0;
            m_digit = (m_digit + 1) % DIGITS;
        end

        e.cnt  = m_cnt;
        e.gray = gray_of(m_cnt);
        e.wrp  = w;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising edge that has a prediction pending gets compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count_bin",  int'(count_bin),  e.cnt);
                check("count_gray", int'(count_gray), e.gray);
                check("wrap",       int'(wrap),       e.wrp);
                check("seg",        int'(seg),        e.sg);
                check("an",         int'(an),         e.a);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count_bin"},  int'(count_bin),  0);
        check({tag, "_count_gray"}, int'(count_gray), 0);
        check({tag, "_wrap"},       int'(wrap),       0);
        check({tag, "_seg"},        int'(seg),        0);
        check({tag, "_an"},         int'(an),         0);
    endtask

    // Watchdog so the run always ends with a summary.
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        // Held reset across two edges.
        @(posedge clk);
        #1;
        check_reset_outputs("init_rst");
        @(posedge clk);
        model_reset();

        // Up count from 0.
        repeat (16) cycle(1, 1, 0, 0, 0);

        // Up wrap from 0xFF.
        cycle(0, 1, 0, 1, 'hFF);
        repeat (6) cycle(1, 1, 0, 0, 0);

        // Down wrap from 0x00, then hold.
        cycle(0, 0, 0, 1, 'h00);
        repeat (5) cycle(1, 0, 0, 0, 0);
        repeat (20) cycle(0, 0, 0, 0, 0);

        // Display of 0x2A in Gray then binary.
        cycle(0, 1, 1, 1, 'h2A);
        repeat (8) cycle(0, 1, 1, 0, 0);
        repeat (8) cycle(0, 1, 0, 0, 0);

        // Load coinciding with a tick.
        for (int i = 0; i < TICK_DIV && m_since != TICK_DIV - 1; i++)
            cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 'h10);
        repeat (6) cycle(1, 1, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0,
                  int'($urandom_range(0, 255)));
        end

        // Asynchronous reset between edges at 0x37.
        cycle(0, 1, 0, 1, 'h37);
        repeat (3) cycle(0, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (6) cycle(1, 1, 0, 0, 0);

        // Let the monitor consume the remaining predictions.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
